// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-state issue/writeback controller sitting in front of a combinational ALU.
// Optional: define ALU_ISSUE_IMM_EN so that instr[10] selects the sign-extended imm10 as operand b.
module alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [5:0]        alu_op,
    input  logic [DATA_W-1:0] alu_ans1,
    input  logic              alu_ans2,
    input  logic              alu_z,
    input  logic              alu_n,
    output logic              done,
    output logic              err,
    output logic [2:0]        flags
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DECODE    = 2'd1;
    localparam logic [1:0] EXECUTE   = 2'd2;
    localparam logic [1:0] WRITEBACK = 2'd3;
    localparam int NREG = 1 << REG_AW;

    logic [1:0]        state;
    logic [DATA_W-1:0] rf [NREG];
    logic [5:0]        op_q;
    logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
    logic [DATA_W-1:0] rs1_val, rs2_val, opb_val, wb_data;
    logic              legal, is_arith;

    // Register 0 is hard-wired to zero on every read path.
    assign rs1_val     = (rs1_q == '0) ? '0 : rf[rs1_q];
    assign rs2_val     = (rs2_q == '0) ? '0 : rf[rs2_q];
    assign dbg_data    = (dbg_addr == '0) ? '0 : rf[dbg_addr];
    assign instr_ready = (state == IDLE);

    assign legal    = op_q[5] ^ op_q[4];
    assign is_arith = (op_q[5:4] == 2'b01);
    assign wb_data  = is_arith ? alu_ans1 : {{(DATA_W-1){1'b0}}, alu_ans2};

`ifdef ALU_ISSUE_IMM_EN
    logic       imm_sel_q;
    logic [9:0] imm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
        end else if (state == IDLE && instr_valid) begin
            imm_sel_q <= instr[10];
            imm_q     <= instr[9:0];
        end
    end

    assign opb_val = imm_sel_q ? {{(DATA_W-10){imm_q[9]}}, imm_q} : rs2_val;
`else
    logic unused_imm;
    assign unused_imm = ^instr[10:0];
    assign opb_val    = rs2_val;
`endif

    // NOTE: every state element here uses non-blocking assignment, so a writeback and an
    // operand read on the same edge would see the pre-edge register value (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= '0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            flags  <= '0;
            // NOTE: the register file is cleared by reset, so it is built from flops, not a RAM macro.
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_en && wr_addr != '0) rf[wr_addr] <= wr_data;
                    if (instr_valid) begin
                        op_q  <= instr[31:26];
                        rd_q  <= instr[21 +: REG_AW];
                        rs1_q <= instr[16 +: REG_AW];
                        rs2_q <= instr[11 +: REG_AW];
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    // Illegal ops leave the ALU inputs untouched.
                    if (legal) begin
                        alu_a  <= rs1_val;
                        alu_b  <= opb_val;
                        alu_op <= op_q;
                    end
                    state <= EXECUTE;
                end
                EXECUTE: state <= WRITEBACK;
                WRITEBACK: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (legal) begin
                        if (rd_q != '0) rf[rd_q] <= wb_data;
                        if (is_arith) flags <= {alu_ans2, alu_z, alu_n};
                    end else begin
                        err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized instructions
// checked against a register/flag reference model and a behavioural ALU stand-in.
module tb_alu_issue_ctrl;
    localparam logic [5:0] OP_ADD = 6'b010000;
    localparam logic [5:0] OP_SUB = 6'b010001;
    localparam logic [5:0] OP_AND = 6'b010010;
    localparam logic [5:0] OP_XOR = 6'b010011;
    localparam logic [5:0] OP_EQ  = 6'b100000;
    localparam logic [5:0] OP_LTU = 6'b100001;

    logic        clk = 1'b0;
    logic        rst, instr_valid, instr_ready, wr_en, done, err;
    logic [31:0] instr, wr_data, dbg_data, alu_a, alu_b, alu_ans1;
    logic [4:0]  wr_addr, dbg_addr;
    logic [5:0]  alu_op;
    logic        alu_ans2, alu_z, alu_n;
    logic [2:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] mr [32];
    logic [2:0]  mf;
    logic [31:0] m_a, m_b;
    logic [5:0]  m_op;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_ans1(alu_ans1), .alu_ans2(alu_ans2), .alu_z(alu_z),
        .alu_n(alu_n), .done(done), .err(err), .flags(flags)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {ans2, ans1}.
    function automatic logic [32:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  alu_fn = {1'b0, a} + {1'b0, b};
            OP_SUB:  alu_fn = {(a < b), a - b};
            OP_AND:  alu_fn = {1'b0, a & b};
            OP_XOR:  alu_fn = {1'b0, a ^ b};
            OP_EQ:   alu_fn = {(a == b), 32'h0};
            OP_LTU:  alu_fn = {(a < b), 32'h0};
            default: alu_fn = {1'b0, a};
        endcase
    endfunction

    always_comb begin
        {alu_ans2, alu_ans1} = alu_fn(alu_op, alu_a, alu_b);
        alu_z = (alu_ans1 == 32'h0);
        alu_n = alu_ans1[31];
    end

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic isel, input logic [9:0] imm);
        enc = {op, rd, rs1, rs2, isel, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mr[i] = 32'h0;
        mf = 3'b000; m_a = 32'h0; m_b = 32'h0; m_op = 6'h0;
    endtask

    // Applies one instruction to the model; returns whether it should raise err.
    task automatic model_exec(input logic [31:0] ins, output logic exp_err);
        logic [5:0]  op;
        logic [31:0] a, b, res;
        logic        c;
        op = ins[31:26];
        a  = mr[ins[20:16]];
        b  = mr[ins[15:11]];
`ifdef ALU_ISSUE_IMM_EN
        if (ins[10]) b = {{22{ins[9]}}, ins[9:0]};
`endif
        exp_err = 1'b0;
        if (op[5:4] == 2'b01 || op[5:4] == 2'b10) begin
            m_a = a; m_b = b; m_op = op;
            {c, res} = alu_fn(op, a, b);
            if (op[5:4] == 2'b01) begin
                if (ins[25:21] != 5'd0) mr[ins[25:21]] = res;
                mf = {c, (res == 32'h0), res[31]};
            end else if (ins[25:21] != 5'd0) begin
                mr[ins[25:21]] = {31'h0, c};
            end
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic host_write(input logic [4:0] addr, input logic [31:0] data);
        for (int w = 0; w < 20 && !instr_ready; w++) tick();
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
        if (addr != 5'd0) mr[addr] = data;
    endtask

    task automatic rd_dbg(input logic [4:0] addr, output logic [31:0] val);
        dbg_addr = addr;
        #1;
        val = dbg_data;
    endtask

    // Issues one instruction and follows it to done; lat = 0 means done never came.
    task automatic issue(input logic [31:0] ins, output int lat, output logic [31:0] sa, output logic [31:0] sb,
                         output logic [5:0] sop, output logic serr, output logic one_cycle);
        lat = 0; sa = 32'h0; sb = 32'h0; sop = 6'h0; serr = 1'b0;
        instr = ins; instr_valid = 1'b1;
        for (int w = 0; w < 20 && !instr_ready; w++) tick();
        tick();
        instr_valid = 1'b0;
        instr = $urandom;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) begin sa = alu_a; sb = alu_b; sop = alu_op; end
            if (done) begin lat = k; serr = err; break; end
        end
        tick();
        one_cycle = !done && !err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat, ndone, idx;
        int          dt [3];
        logic [31:0] sa, sb, v, ins;
        logic [31:0] prog [3];
        logic [5:0]  sop;
        logic [5:0]  ops [8];
        logic        serr, one, eerr, acc;

        ops = '{OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_EQ, OP_LTU, 6'b000000, 6'b110101};
        rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; wr_en = 1'b0;
        wr_addr = 5'd0; wr_data = 32'h0; dbg_addr = 5'd0;
        model_reset();
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_ready", instr_ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_flags", flags, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        rd_dbg(5'd1, v); check("rst_r1", v, 0);

        // ADD r3 = r1 + r2
        host_write(5'd1, 32'h11);
        host_write(5'd2, 32'h01);
        ins = enc(OP_ADD, 5'd3, 5'd1, 5'd2, 1'b0, 10'h0);
        model_exec(ins, eerr);
        issue(ins, lat, sa, sb, sop, serr, one);
        check("add_alu_op", sop, OP_ADD);
        check("add_alu_a", sa, 32'h11);
        check("add_alu_b", sb, 32'h01);
        check("add_latency", lat, 3);
        check("add_err", serr, 0);
        check("add_done_pulse", one, 1);
        rd_dbg(5'd3, v); check("add_r3", v, 32'h12);
        check("add_flags", flags, 3'b000);

        // SUB r4 = r2 - r2, then EQ r5 = (r1 == r1)
        ins = enc(OP_SUB, 5'd4, 5'd2, 5'd2, 1'b0, 10'h0);
        model_exec(ins, eerr);
        issue(ins, lat, sa, sb, sop, serr, one);
        rd_dbg(5'd4, v); check("sub_r4", v, 32'h0);
        check("sub_flags", flags, 3'b010);
        ins = enc(OP_EQ, 5'd5, 5'd1, 5'd1, 1'b0, 10'h0);
        model_exec(ins, eerr);
        issue(ins, lat, sa, sb, sop, serr, one);
        rd_dbg(5'd5, v); check("eq_r5", v, 32'h1);
        check("eq_flags", flags, 3'b010);

        // Illegal opcodes
        ins = enc(6'b000000, 5'd6, 5'd1, 5'd2, 1'b0, 10'h0);
        model_exec(ins, eerr);
        issue(ins, lat, sa, sb, sop, serr, one);
        check("ill0_latency", lat, 3);
        check("ill0_err", serr, 1);
        check("ill0_pulse", one, 1);
        check("ill0_alu_op", sop, OP_EQ);
        ins = enc(6'b110101, 5'd3, 5'd1, 5'd2, 1'b0, 10'h0);
        model_exec(ins, eerr);
        issue(ins, lat, sa, sb, sop, serr, one);
        check("ill1_err", serr, 1);
        check("ill1_alu_op", sop, m_op);
        check("ill1_flags", flags, 3'b010);
        rd_dbg(5'd3, v); check("ill1_r3", v, 32'h12);
        rd_dbg(5'd6, v); check("ill1_r6", v, 32'h0);

        // Reset during EXECUTE of an ADD into r6
        instr = enc(OP_ADD, 5'd6, 5'd1, 5'd2, 1'b0, 10'h0); instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("abort_ready", instr_ready, 1);
        check("abort_flags", flags, 0);
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) ndone++;
            tick();
        end
        check("abort_no_done", ndone, 0);
        for (int r = 0; r < 32; r++) begin
            rd_dbg(r[4:0], v);
            check($sformatf("abort_r%0d", r), v, 32'h0);
        end

        // Back-to-back ADDs with instr_valid held high and wr_en noise
        host_write(5'd1, 32'h5);
        host_write(5'd2, 32'h7);
        prog[0] = enc(OP_ADD, 5'd8, 5'd1, 5'd2, 1'b0, 10'h0);
        prog[1] = enc(OP_ADD, 5'd9, 5'd8, 5'd1, 1'b0, 10'h0);
        prog[2] = enc(OP_ADD, 5'd10, 5'd9, 5'd9, 1'b0, 10'h0);
        for (int i = 0; i < 3; i++) model_exec(prog[i], eerr);
        idx = 0; ndone = 0; dt = '{0, 0, 0};
        instr = prog[0]; instr_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            wr_en   = 1'b1;
            wr_addr = instr_ready ? 5'd0 : 5'd1;
            wr_data = $urandom;
            acc     = instr_ready && instr_valid;
            tick();
            if (done) begin
                if (ndone < 3) dt[ndone] = cyc;
                ndone++;
            end
            if (acc) begin
                idx++;
                if (idx < 3) instr = prog[idx];
                else instr_valid = 1'b0;
            end
        end
        wr_en = 1'b0;
        check("b2b_done_count", ndone, 3);
        check("b2b_gap0", dt[1] - dt[0], 4);
        check("b2b_gap1", dt[2] - dt[1], 4);
        rd_dbg(5'd8, v);  check("b2b_r8", v, mr[8]);
        rd_dbg(5'd9, v);  check("b2b_r9", v, mr[9]);
        rd_dbg(5'd10, v); check("b2b_r10", v, mr[10]);
        rd_dbg(5'd1, v);  check("b2b_r1_kept", v, 32'h5);
        rd_dbg(5'd0, v);  check("b2b_r0_zero", v, 32'h0);
        check("b2b_flags", flags, mf);

        // Immediate operand (or register rs2 when the feature is compiled out)
        host_write(5'd1, 32'h11);
        ins = enc(OP_ADD, 5'd7, 5'd1, 5'd2, 1'b1, 10'h3FF);
        model_exec(ins, eerr);
        issue(ins, lat, sa, sb, sop, serr, one);
`ifdef ALU_ISSUE_IMM_EN
        check("imm_alu_b", sb, 32'hFFFF_FFFF);
        rd_dbg(5'd7, v); check("imm_r7", v, 32'h10);
        check("imm_flags", flags, 3'b100);
`else
        check("imm_alu_b", sb, 32'h7);
        rd_dbg(5'd7, v); check("imm_r7", v, 32'h18);
        check("imm_flags", flags, 3'b000);
`endif

        // Randomized instructions against the model
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0)
                host_write(5'($urandom_range(0, 7)), $urandom);
            ins = enc(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 10'($urandom));
            model_exec(ins, eerr);
            issue(ins, lat, sa, sb, sop, serr, one);
            check($sformatf("rnd%0d_latency", t), lat, 3);
            check($sformatf("rnd%0d_err", t), serr, eerr);
            check($sformatf("rnd%0d_alu_op", t), sop, m_op);
            check($sformatf("rnd%0d_alu_a", t), sa, m_a);
            check($sformatf("rnd%0d_alu_b", t), sb, m_b);
            rd_dbg(ins[25:21], v);
            check($sformatf("rnd%0d_rd", t), v, mr[ins[25:21]]);
            check($sformatf("rnd%0d_flags", t), flags, mf);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
